// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle RV32I sequencer with memory handshake stall and watchdog abort
module multicycle_control_fsm #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_update,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       illegal_instr,
  output logic       bus_err
);
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BQ = 7'b1100011;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ
  } state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             stall, abort;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_update     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    result_src    = 2'b00;
    illegal_instr = 1'b0;
    bus_err       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        state_d    = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b01;
        illegal_instr = !(opcode inside {OP_LW, OP_SW, OP_R, OP_I, OP_BQ});
        state_d       = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                        (opcode == OP_R)  ? EXECR :
                        (opcode == OP_I)  ? EXECI :
                        (opcode == OP_BQ) ? BEQ : FETCH;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        state_d = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        state_d   = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_update = zero;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
    stall   = mem_req && !mem_ready;
    abort   = (WAIT_LIMIT != 0) && stall && (stall_q == CNT_W'(WAIT_LIMIT));
    stall_d = stall ? stall_q + 1'b1 : '0;
    // a completing mem_ready never reaches here as a stall, so completion beats the limit
    if (abort) begin
      state_d   = FETCH;
      stall_d   = '0;
      bus_err   = 1'b1;
      ir_write  = 1'b0;
      pc_update = 1'b0;
      reg_write = 1'b0;
    end
    if (!rst_n) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_update     = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      bus_err       = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b10;
      alu_op        = 2'b00;
      result_src    = 2'b10;
    end
  end
  always_comb imm_src = (opcode == OP_SW) ? 2'b01 : (opcode == OP_BQ) ? 2'b10 : 2'b00;
endmodule
